baby_kyber_encrypt: RTL and testbench

Sequential Baby-Kyber encryption stage, directly downstream of key generation. It consumes the public key (matrix A and vector t, each coefficient signed 32-bit) plus encryption randomness and a 4-bit message, and produces the ciphertext (u, v) over Z_Q[x]/(x^4+1). The datapath is a single modular multiply-accumulate unit time-shared over all polynomial products; N=4 and K=2 are fixed.

---
 rtl/baby_kyber_encrypt_if.sv | 25 ++
 rtl/baby_kyber_encrypt.sv | 142 ++++++++++++++
 tb/tb_baby_kyber_encrypt.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/baby_kyber_encrypt_if.sv
// Request/response bundle for the Baby-Kyber encryption stage: public key,
// randomness, message and start on one side; busy/done and ciphertext on the other.
interface baby_kyber_encrypt_if;
  logic                          start;
  logic                          busy;
  logic                          done;
  logic signed [3:0][3:0][31:0]  A;
  logic signed [1:0][3:0][31:0]  t;
  logic signed [1:0][3:0][31:0]  r;
  logic signed [1:0][3:0][31:0]  e1;
  logic signed [3:0][31:0]       e2;
  logic        [3:0]             m;
  logic signed [1:0][3:0][31:0]  u;
  logic signed [3:0][31:0]       v;

  modport master (
    output start, A, t, r, e1, e2, m,
    input  busy, done, u, v
  );

  modport slave (
    input  start, A, t, r, e1, e2, m,
    output busy, done, u, v
  );
endinterface

// File: rtl/baby_kyber_encrypt.sv
// Baby-Kyber encryption over Z_Q[x]/(x^4+1) using one time-shared modular
// multiply-accumulate unit; 96 MAC cycles cover all six polynomial products.
module baby_kyber_encrypt #(
  parameter int Q         = 17,
  parameter int MSG_SCALE = 9
) (
  input logic clk,
  input logic rst_n,
  baby_kyber_encrypt_if.slave bus
);
  localparam int W  = $clog2(Q);
  localparam int PW = 2 * W;
  localparam logic [W-1:0] MS = W'(MSG_SCALE % Q);

  typedef logic [W-1:0] coef_t;
  typedef enum logic [2:0] {IDLE, CAPTURE, MAC, FINAL, DONE} state_t;

  state_t state, state_next;

  coef_t      ar  [4][4];
  coef_t      tr  [2][4];
  coef_t      rr  [2][4];
  coef_t      e1r [2][4];
  coef_t      e2r [4];
  logic [3:0] mr;
  coef_t      acc [3][4];
  logic [6:0] cnt;

  function automatic coef_t reduce(input logic signed [31:0] x);
    logic signed [31:0] rm;
    rm = x % Q;
    if (rm < 0) rm = rm + Q;
    return rm[W-1:0];
  endfunction

  function automatic coef_t mod_add(input coef_t x, input coef_t y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return s[W-1:0];
  endfunction

  function automatic coef_t mod_neg(input coef_t x);
    return (x == '0) ? '0 : W'(Q - int'(x));
  endfunction

  // The MAC counter is the nested (p, j, i, l) loop packed into one word, l innermost.
  logic [1:0] p_idx, i_idx, l_idx, k_idx;
  logic       j_idx, wrap;
  coef_t      a_op, b_op, prod_mod, acc_cur, acc_next;
  logic [PW-1:0] prod;

  assign p_idx = cnt[6:5];
  assign j_idx = cnt[4];
  assign i_idx = cnt[3:2];
  assign l_idx = cnt[1:0];
  assign {wrap, k_idx} = {1'b0, i_idx} + {1'b0, l_idx};

  always_comb begin
    a_op = '0;
    case (p_idx)
      2'd0:    a_op = ar[{j_idx, 1'b0}][i_idx];
      2'd1:    a_op = ar[{j_idx, 1'b1}][i_idx];
      default: a_op = tr[j_idx][i_idx];
    endcase
    b_op     = rr[j_idx][l_idx];
    prod     = PW'(a_op) * PW'(b_op);
    prod_mod = W'(prod % PW'(Q));
    acc_cur  = acc[p_idx][k_idx];
    // x^4 = -1: terms that wrap past degree 3 are subtracted
    acc_next = wrap ? mod_add(acc_cur, mod_neg(prod_mod)) : mod_add(acc_cur, prod_mod);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_next = CAPTURE;
      end
      CAPTURE: state_next = MAC;
      MAC:     if (cnt == 7'd95) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? CAPTURE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ar    <= '{default: '0};
      tr    <= '{default: '0};
      rr    <= '{default: '0};
      e1r   <= '{default: '0};
      e2r   <= '{default: '0};
      mr    <= '0;
      acc   <= '{default: '0};
      cnt   <= '0;
      bus.u <= '0;
      bus.v <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++) ar[p][k] <= reduce($signed(bus.A[p][k]));
            for (int p = 0; p < 2; p++) begin
              tr[p][k]  <= reduce($signed(bus.t[p][k]));
              rr[p][k]  <= reduce($signed(bus.r[p][k]));
              e1r[p][k] <= reduce($signed(bus.e1[p][k]));
            end
            e2r[k] <= reduce($signed(bus.e2[k]));
          end
          mr  <= bus.m;
          acc <= '{default: '0};
          cnt <= '0;
        end
        MAC: begin
          acc[p_idx][k_idx] <= acc_next;
          cnt <= (cnt == 7'd95) ? '0 : cnt + 7'd1;
        end
        FINAL: begin
          for (int k = 0; k < 4; k++) begin
            bus.u[0][k] <= 32'(mod_add(acc[0][k], e1r[0][k]));
            bus.u[1][k] <= 32'(mod_add(acc[1][k], e1r[1][k]));
            bus.v[k]    <= 32'(mod_add(mod_add(acc[2][k], e2r[k]), mr[k] ? MS : '0));
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_baby_kyber_encrypt.sv
// Randomized and directed checks of baby_kyber_encrypt against a plain
// negacyclic-polynomial reference model.
module tb_baby_kyber_encrypt;
  localparam int Q         = 17;
  localparam int MSG_SCALE = 9;

  typedef logic signed [1:0][3:0][31:0] upoly_t;
  typedef logic signed [3:0][31:0]      vpoly_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  baby_kyber_encrypt_if bus();

  baby_kyber_encrypt #(.Q(Q), .MSG_SCALE(MSG_SCALE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         mA  [4][4];
  int         mt  [2][4];
  int         mr  [2][4];
  int         me1 [2][4];
  int         me2 [4];
  logic [3:0] mm;

  function automatic int md(input int x);
    int rm;
    rm = x % Q;
    if (rm < 0) rm += Q;
    return rm;
  endfunction

  function automatic int rnd_coef();
    if ($urandom_range(0, 3) == 0) return int'($urandom());
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) mA[p][k] = 0;
      for (int p = 0; p < 2; p++) begin
        mt[p][k] = 0; mr[p][k] = 0; me1[p][k] = 0;
      end
      me2[k] = 0;
    end
    mm = 4'b0;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) mA[p][k] = rnd_coef();
      for (int p = 0; p < 2; p++) begin
        mt[p][k] = rnd_coef(); mr[p][k] = rnd_coef(); me1[p][k] = rnd_coef();
      end
      me2[k] = rnd_coef();
    end
    mm = 4'($urandom());
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) bus.A[p][k] = mA[p][k];
      for (int p = 0; p < 2; p++) begin
        bus.t[p][k] = mt[p][k]; bus.r[p][k] = mr[p][k]; bus.e1[p][k] = me1[p][k];
      end
      bus.e2[k] = me2[k];
    end
    bus.m = mm;
  endtask

  // Schoolbook negacyclic products: a[i]*b[l] lands on x^(i+l), with x^4 = -1.
  task automatic model(output upoly_t eu, output vpoly_t ev);
    int su [2][4];
    int sv [4];
    for (int k = 0; k < 4; k++) begin
      su[0][k] = md(me1[0][k]);
      su[1][k] = md(me1[1][k]);
      sv[k]    = md(me2[k]) + (mm[k] ? MSG_SCALE : 0);
    end
    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < 4; l++) begin
        int k  = (i + l) % 4;
        int sg = (i + l >= 4) ? -1 : 1;
        su[0][k] += sg * (md(mA[0][i]) * md(mr[0][l]) + md(mA[2][i]) * md(mr[1][l]));
        su[1][k] += sg * (md(mA[1][i]) * md(mr[0][l]) + md(mA[3][i]) * md(mr[1][l]));
        sv[k]    += sg * (md(mt[0][i]) * md(mr[0][l]) + md(mt[1][i]) * md(mr[1][l]));
      end
    end
    for (int k = 0; k < 4; k++) begin
      eu[0][k] = md(su[0][k]);
      eu[1][k] = md(su[1][k]);
      ev[k]    = md(sv[k]);
    end
  endtask

  // Pulses start and returns at the first falling edge where done is seen.
  task automatic run_op(output int lat);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0;
    clear_inputs();
    apply_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.u !== '0) $display("[TB] FAIL reset_u: got %h expected 0", bus.u); else passes++;
    checks++; if (bus.v !== '0) $display("[TB] FAIL reset_v: got %h expected 0", bus.v); else passes++;
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    upoly_t eu;
    vpoly_t ev;
    int     lat;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      eu = '0;
      ev = '0;
      case (c)
        0: begin mm = 4'b1011; ev[0] = 9; ev[1] = 9; ev[3] = 9; end
        1: begin mA[0][3] = 1; mr[0][1] = 1; eu[0][0] = 16; end
        2: begin
          for (int k = 0; k < 4; k++) begin
            mt[0][k] = k + 1; me2[k] = 1; ev[k] = k + 2;
          end
          mr[0][0] = 1;
        end
        default: begin
          me1[0][0] = -1; me1[0][1] = -18; me1[0][2] = 17; me1[0][3] = 35;
          eu[0][0] = 16; eu[0][1] = 16; eu[0][2] = 0; eu[0][3] = 1;
        end
      endcase
      apply_inputs();
      run_op(lat);
      checks++; if (lat !== 98) $display("[TB] FAIL directed%0d_latency: got %0d expected 98", c, lat); else passes++;
      checks++; if (bus.u !== eu) $display("[TB] FAIL directed%0d_u: got %h expected %h", c, bus.u, eu); else passes++;
      checks++; if (bus.v !== ev) $display("[TB] FAIL directed%0d_v: got %h expected %h", c, bus.v, ev); else passes++;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("[TB] FAIL directed%0d_done_width: got done=%b busy=%b expected 0 0", c, bus.done, bus.busy);
      else passes++;
    end
  endtask

  task automatic test_random();
    upoly_t eu;
    vpoly_t ev;
    int     lat;
    for (int n = 0; n < 20; n++) begin
      randomize_inputs();
      apply_inputs();
      model(eu, ev);
      run_op(lat);
      checks++; if (lat !== 98) $display("[TB] FAIL random%0d_latency: got %0d expected 98", n, lat); else passes++;
      checks++; if (bus.u !== eu) $display("[TB] FAIL random%0d_u: got %h expected %h", n, bus.u, eu); else passes++;
      checks++; if (bus.v !== ev) $display("[TB] FAIL random%0d_v: got %h expected %h", n, bus.v, ev); else passes++;
    end
  endtask

  task automatic test_ignore_start();
    upoly_t eu;
    vpoly_t ev;
    int     lat;
    int     extra;
    randomize_inputs();
    apply_inputs();
    model(eu, ev);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk); lat++;
      if (lat == 1) begin randomize_inputs(); apply_inputs(); end
      if (lat == 40) bus.start = 1'b1;
      if (lat == 41) bus.start = 1'b0;
    end
    checks++; if (lat !== 98) $display("[TB] FAIL ignore_latency: got %0d expected 98", lat); else passes++;
    checks++; if (bus.u !== eu) $display("[TB] FAIL ignore_u: got %h expected %h", bus.u, eu); else passes++;
    checks++; if (bus.v !== ev) $display("[TB] FAIL ignore_v: got %h expected %h", bus.v, ev); else passes++;
    extra = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++; if (extra !== 0) $display("[TB] FAIL ignore_extra_done: got %0d expected 0", extra); else passes++;
  endtask

  task automatic test_reset_mid_mac();
    upoly_t eu;
    vpoly_t ev;
    int     lat;
    randomize_inputs();
    apply_inputs();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (51) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.u !== '0) $display("[TB] FAIL midreset_u: got %h expected 0", bus.u); else passes++;
    checks++; if (bus.v !== '0) $display("[TB] FAIL midreset_v: got %h expected 0", bus.v); else passes++;
    @(negedge clk);
    rst_n = 1'b0;
    randomize_inputs();
    apply_inputs();
    model(eu, ev);
    run_op(lat);
    checks++; if (lat !== 98) $display("[TB] FAIL postreset_latency: got %0d expected 98", lat); else passes++;
    checks++; if (bus.u !== eu) $display("[TB] FAIL postreset_u: got %h expected %h", bus.u, eu); else passes++;
    checks++; if (bus.v !== ev) $display("[TB] FAIL postreset_v: got %h expected %h", bus.v, ev); else passes++;
  endtask

  task automatic test_back_to_back();
    upoly_t eu;
    vpoly_t ev;
    int     lat;
    randomize_inputs();
    apply_inputs();
    model(eu, ev);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk); lat++;
    end
    checks++; if (lat !== 98) $display("[TB] FAIL b2b_first_latency: got %0d expected 98", lat); else passes++;
    checks++; if (bus.u !== eu) $display("[TB] FAIL b2b_first_u: got %h expected %h", bus.u, eu); else passes++;
    checks++; if (bus.v !== ev) $display("[TB] FAIL b2b_first_v: got %h expected %h", bus.v, ev); else passes++;
    randomize_inputs();
    apply_inputs();
    model(eu, ev);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!bus.done && lat < 200);
    bus.start = 1'b0;
    checks++; if (lat !== 99) $display("[TB] FAIL b2b_period: got %0d expected 99", lat); else passes++;
    checks++; if (bus.u !== eu) $display("[TB] FAIL b2b_second_u: got %h expected %h", bus.u, eu); else passes++;
    checks++; if (bus.v !== ev) $display("[TB] FAIL b2b_second_v: got %h expected %h", bus.v, ev); else passes++;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("[TB] FAIL b2b_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_mac();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
